// File: rtl/c2c_data_responder_if.sv
// Shared width constants and the c2c_data request/response bus seen by the
// data responder: master drives the request, slave returns ack/data_r.
package pipeline;
    localparam int XLEN = 32;
endpackage

interface c2c_data #(
    parameter int XLEN = pipeline::XLEN
);
    logic                re;
    logic                we;
    logic                atomic;
    logic [4:0]          amo_op;
    logic [XLEN/8-1:0]   sel;
    logic [XLEN-1:0]     addr;
    logic [XLEN-1:0]     data_w;
    logic                ack;
    logic [XLEN-1:0]     data_r;

    modport master (
        output re, we, atomic, amo_op, sel, addr, data_w,
        input  ack, data_r
    );

    modport slave (
        input  re, we, atomic, amo_op, sel, addr, data_w,
        output ack, data_r
    );
endinterface

// File: rtl/c2c_data_responder.sv
// Local-RAM responder for the c2c_data bus: byte-masked reads/writes,
// LR/SC reservation and RISC-V AMO read-modify-write operations.
module c2c_data_responder #(
    parameter int XLEN        = pipeline::XLEN,
    parameter int DEPTH_WORDS = 1024
) (
    input logic   clk,
    input logic   reset_n,
    c2c_data.slave bus
);
    localparam int          AW = $clog2(DEPTH_WORDS);
    localparam int unsigned NB = XLEN / 8;

    localparam logic [4:0] AMO_ADD  = 5'b00000;
    localparam logic [4:0] AMO_SWAP = 5'b00001;
    localparam logic [4:0] AMO_LR   = 5'b00010;
    localparam logic [4:0] AMO_SC   = 5'b00011;
    localparam logic [4:0] AMO_XOR  = 5'b00100;
    localparam logic [4:0] AMO_OR   = 5'b01000;
    localparam logic [4:0] AMO_AND  = 5'b01100;
    localparam logic [4:0] AMO_MIN  = 5'b10000;
    localparam logic [4:0] AMO_MAX  = 5'b10100;
    localparam logic [4:0] AMO_MINU = 5'b11000;
    localparam logic [4:0] AMO_MAXU = 5'b11100;

    typedef enum logic [1:0] {IDLE, RESP, AMO_MOD} state_t;
    typedef enum logic [1:0] {K_LR, K_SC, K_RMW, K_BAD} amo_kind_t;

    state_t           r_state;
    state_t           w_next;
    amo_kind_t        w_kind;

    logic [XLEN-1:0]  r_mem [DEPTH_WORDS];
    logic [AW-1:0]    r_idx;
    logic [AW-1:0]    r_resv_idx;
    logic             r_resv_valid;
    logic [4:0]       r_amo_op;
    logic [XLEN-1:0]  r_data_w;
    logic [XLEN-1:0]  r_old;
    logic [XLEN-1:0]  r_data_r;

    logic [AW-1:0]    w_req_idx;
    logic [XLEN-1:0]  w_rd_word;
    logic [XLEN-1:0]  w_amo_result;
    logic             w_sc_ok;
    logic             w_accept;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_idx;
    logic [XLEN-1:0]  w_mem_wdata;
    logic [NB-1:0]    w_mem_be;
    logic             w_unused_addr;

    // Byte offset and bits above the RAM size are dropped, so addresses wrap.
    assign w_req_idx     = bus.addr[AW+1:2];
    assign w_unused_addr = ^{bus.addr[XLEN-1:AW+2], bus.addr[1:0]};
    assign w_rd_word     = r_mem[w_req_idx];
    assign w_sc_ok       = r_resv_valid && (r_resv_idx == w_req_idx);

    assign bus.ack    = (r_state == RESP);
    assign bus.data_r = r_data_r;

    always_comb begin
        case (bus.amo_op)
            AMO_LR:   w_kind = K_LR;
            AMO_SC:   w_kind = K_SC;
            AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU:
                      w_kind = K_RMW;
            default:  w_kind = K_BAD;
        endcase
    end

    always_comb begin
        w_amo_result = r_old;
        case (r_amo_op)
            AMO_SWAP: w_amo_result = r_data_w;
            AMO_ADD:  w_amo_result = r_old + r_data_w;
            AMO_XOR:  w_amo_result = r_old ^ r_data_w;
            AMO_AND:  w_amo_result = r_old & r_data_w;
            AMO_OR:   w_amo_result = r_old | r_data_w;
            AMO_MIN:  w_amo_result = ($signed(r_old) < $signed(r_data_w)) ? r_old : r_data_w;
            AMO_MAX:  w_amo_result = ($signed(r_old) > $signed(r_data_w)) ? r_old : r_data_w;
            AMO_MINU: w_amo_result = (r_old < r_data_w) ? r_old : r_data_w;
            AMO_MAXU: w_amo_result = (r_old > r_data_w) ? r_old : r_data_w;
            default:  w_amo_result = r_old;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_idx   = w_req_idx;
        w_mem_wdata = bus.data_w;
        w_mem_be    = '0;
        case (r_state)
            IDLE: begin
                if (bus.re || bus.we || bus.atomic) begin
                    w_accept = 1'b1;
                    w_next   = RESP;
                    if (bus.atomic) begin
                        if (w_kind == K_RMW) begin
                            w_next = AMO_MOD;
                        end else if (w_kind == K_SC && w_sc_ok) begin
                            w_mem_we = 1'b1;
                            w_mem_be = '1;
                        end
                    end else if (bus.we) begin
                        w_mem_we = 1'b1;
                        w_mem_be = bus.sel;
                    end
                end
            end
            AMO_MOD: begin
                w_mem_we    = 1'b1;
                w_mem_idx   = r_idx;
                w_mem_wdata = w_amo_result;
                w_mem_be    = '1;
                w_next      = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // RAM has no reset; gating with reset_n drops any write in a reset cycle.
    always_ff @(posedge clk) begin
        if (reset_n && w_mem_we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data_r     <= '0;
            r_resv_valid <= 1'b0;
            r_resv_idx   <= '0;
            r_idx        <= '0;
            r_amo_op     <= '0;
            r_data_w     <= '0;
            r_old        <= '0;
        end else begin
            // Generic clear first; LR/SC handling below takes precedence.
            if (w_mem_we && r_resv_valid && (r_resv_idx == w_mem_idx)) begin
                r_resv_valid <= 1'b0;
            end
            if (w_accept) begin
                r_idx    <= w_req_idx;
                r_amo_op <= bus.amo_op;
                r_data_w <= bus.data_w;
                r_old    <= w_rd_word;
                if (bus.atomic) begin
                    case (w_kind)
                        K_LR: begin
                            r_data_r     <= w_rd_word;
                            r_resv_valid <= 1'b1;
                            r_resv_idx   <= w_req_idx;
                        end
                        K_SC: begin
                            r_data_r     <= w_sc_ok ? '0 : XLEN'(1);
                            r_resv_valid <= 1'b0;
                        end
                        K_RMW: begin
                            r_data_r <= r_data_r;
                        end
                        default: r_data_r <= w_rd_word;
                    endcase
                end else if (bus.we) begin
                    r_data_r <= '0;
                end else begin
                    r_data_r <= w_rd_word;
                end
            end
            if (r_state == AMO_MOD) begin
                r_data_r <= r_old;
            end
        end
    end

endmodule

// File: tb/tb_c2c_data_responder.sv
// Bench for c2c_data_responder: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a word-array reference model.
module tb_c2c_data_responder;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SWAP = 5'b00001;
    localparam logic [4:0] OP_LR   = 5'b00010;
    localparam logic [4:0] OP_SC   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_MIN  = 5'b10000;
    localparam logic [4:0] OP_MAX  = 5'b10100;
    localparam logic [4:0] OP_MINU = 5'b11000;
    localparam logic [4:0] OP_MAXU = 5'b11100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    c2c_data #(.XLEN(32)) bus_if ();

    c2c_data_responder #(.XLEN(32), .DEPTH_WORDS(1024)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        re;
        logic        we;
        logic        at;
        logic [4:0]  op;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] dw;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] m_mem [16];
    bit          m_rv;
    int          m_ridx;

    logic [31:0] rd;
    int          lat;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic void add_vec(input logic re, we, at, input logic [4:0] op,
                                    input logic [3:0] sel, input logic [31:0] addr, dw,
                                    input logic [31:0] exp_data, input int exp_lat);
        vec_t v;
        v.re = re; v.we = we; v.at = at; v.op = op; v.sel = sel;
        v.addr = addr; v.dw = dw; v.exp_data = exp_data; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endfunction

    // Called at a negedge with the DUT idle; returns on a negedge, idle again.
    task automatic do_req(input logic re_i, we_i, at_i, input logic [4:0] op_i,
                          input logic [3:0] sel_i, input logic [31:0] addr_i, dw_i,
                          output logic [31:0] rdata, output int lat_o);
        bus_if.re = re_i; bus_if.we = we_i; bus_if.atomic = at_i;
        bus_if.amo_op = op_i; bus_if.sel = sel_i;
        bus_if.addr = addr_i; bus_if.data_w = dw_i;
        lat_o = 0;
        rdata = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus_if.ack === 1'b1) begin
                lat_o = c;
                rdata = bus_if.data_r;
                break;
            end
        end
        bus_if.re = 1'b0; bus_if.we = 1'b0; bus_if.atomic = 1'b0;
        @(negedge clk);
        check("ack_single_cycle", {31'b0, bus_if.ack}, 32'd0);
    endtask

    function automatic bit is_rmw(input logic [4:0] op);
        return op inside {OP_ADD, OP_SWAP, OP_XOR, OP_OR, OP_AND,
                          OP_MIN, OP_MAX, OP_MINU, OP_MAXU};
    endfunction

    function automatic logic [31:0] amo_fn(input logic [4:0] op, input logic [31:0] a, b);
        int          sa = int'(a);
        int          sb = int'(b);
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        case (op)
            OP_SWAP: return b;
            OP_ADD:  return 32'((ua + ub) % 64'h1_0000_0000);
            OP_XOR:  return a ^ b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_MIN:  return (sa <= sb) ? a : b;
            OP_MAX:  return (sa >= sb) ? a : b;
            OP_MINU: return (ua <= ub) ? a : b;
            default: return (ua >= ub) ? a : b;
        endcase
    endfunction

    function automatic void model(input logic we, at, input logic [4:0] op, input logic [3:0] sel,
                                  input int idx, input logic [31:0] dw,
                                  output logic [31:0] ed, output int el);
        logic [31:0] old = m_mem[idx];
        el = 1;
        ed = old;
        if (at) begin
            if (op == OP_LR) begin
                m_rv = 1'b1;
                m_ridx = idx;
            end else if (op == OP_SC) begin
                if (m_rv && m_ridx == idx) begin
                    m_mem[idx] = dw;
                    ed = 0;
                end else begin
                    ed = 1;
                end
                m_rv = 1'b0;
            end else if (is_rmw(op)) begin
                el = 2;
                m_mem[idx] = amo_fn(op, old, dw);
                if (m_rv && m_ridx == idx) m_rv = 1'b0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) m_mem[idx][8*b +: 8] = dw[8*b +: 8];
            ed = 0;
            if (m_rv && m_ridx == idx) m_rv = 1'b0;
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.re = 1'b0; bus_if.we = 1'b0; bus_if.atomic = 1'b0;
        bus_if.amo_op = '0; bus_if.sel = '0; bus_if.addr = '0; bus_if.data_w = '0;

        // Table: W=write, R=read; sequential, later rows depend on earlier ones.
        add_vec(0,1,0,OP_ADD, 4'hF, 32'h10, 32'h0,        32'h0,        1);
        add_vec(0,1,0,OP_ADD, 4'h5, 32'h10, 32'hAABBCCDD, 32'h0,        1);
        add_vec(1,0,0,OP_ADD, 4'h0, 32'h10, 32'h0,        32'h00BB00DD, 1);
        add_vec(0,1,0,OP_ADD, 4'hF, 32'h08, 32'h5,        32'h0,        1);
        add_vec(1,0,1,OP_ADD, 4'h0, 32'h08, 32'hFFFFFFFF, 32'h5,        2);
        add_vec(1,0,0,OP_ADD, 4'h0, 32'h08, 32'h0,        32'h4,        1);
        add_vec(0,1,0,OP_ADD, 4'hF, 32'h20, 32'h12345678, 32'h0,        1);
        add_vec(1,0,1,OP_LR,  4'h0, 32'h20, 32'h0,        32'h12345678, 1);
        add_vec(0,1,1,OP_SC,  4'h0, 32'h20, 32'hCAFEF00D, 32'h0,        1);
        add_vec(0,1,1,OP_SC,  4'h0, 32'h20, 32'h11111111, 32'h1,        1);
        add_vec(1,0,0,OP_ADD, 4'h0, 32'h20, 32'h0,        32'hCAFEF00D, 1);
        add_vec(1,0,1,OP_LR,  4'h0, 32'h20, 32'h0,        32'hCAFEF00D, 1);
        add_vec(0,1,0,OP_ADD, 4'hF, 32'h20, 32'h0,        32'h0,        1);
        add_vec(0,1,1,OP_SC,  4'h0, 32'h20, 32'h5,        32'h1,        1);
        add_vec(1,0,0,OP_ADD, 4'h0, 32'h20, 32'h0,        32'h0,        1);
        add_vec(0,1,0,OP_ADD, 4'hF, 32'h30, 32'hFFFFFFFF, 32'h0,        1);
        add_vec(1,0,1,OP_MIN, 4'h0, 32'h30, 32'h1,        32'hFFFFFFFF, 2);
        add_vec(1,0,0,OP_ADD, 4'h0, 32'h30, 32'h0,        32'hFFFFFFFF, 1);
        add_vec(1,0,1,OP_MINU,4'h0, 32'h30, 32'h1,        32'hFFFFFFFF, 2);
        add_vec(1,0,0,OP_ADD, 4'h0, 32'h30, 32'h0,        32'h1,        1);
        add_vec(0,1,0,OP_ADD, 4'h1, 32'h1013, 32'h12345677, 32'h0,      1);
        add_vec(1,0,0,OP_ADD, 4'h0, 32'h10, 32'h0,        32'h00BB0077, 1);
        add_vec(1,0,1,5'b00101,4'h0,32'h10, 32'h99,       32'h00BB0077, 1);
        add_vec(0,1,1,OP_SC,  4'h0, 32'h10, 32'h99,       32'h1,        1);
        add_vec(1,1,0,OP_ADD, 4'hF, 32'h40, 32'hDEADBEEF, 32'h0,        1);
        add_vec(1,0,0,OP_ADD, 4'h0, 32'h40, 32'h0,        32'hDEADBEEF, 1);
        add_vec(1,0,1,OP_MAX, 4'h0, 32'h40, 32'h1,        32'hDEADBEEF, 2);
        add_vec(1,0,0,OP_ADD, 4'h0, 32'h40, 32'h0,        32'h1,        1);

        repeat (3) @(negedge clk);
        check("reset_ack", {31'b0, bus_if.ack}, 32'd0);
        check("reset_data_r", bus_if.data_r, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_req(vecs[i].re, vecs[i].we, vecs[i].at, vecs[i].op, vecs[i].sel,
                   vecs[i].addr, vecs[i].dw, rd, lat);
            check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        end

        // Request presented during RESP must wait for the following IDLE cycle.
        bus_if.re = 1'b1; bus_if.we = 1'b0; bus_if.atomic = 1'b0;
        bus_if.addr = 32'h08; bus_if.sel = '0; bus_if.data_w = '0;
        lat = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (bus_if.ack === 1'b1) begin lat = c; break; end
        end
        check("b2b_first_latency", lat, 1);
        check("b2b_first_data", bus_if.data_r, 32'h4);
        bus_if.addr = 32'h10;
        @(negedge clk);
        check("b2b_resp_not_accepted", {31'b0, bus_if.ack}, 32'd0);
        check("b2b_data_hold", bus_if.data_r, 32'h4);
        @(negedge clk);
        check("b2b_second_ack", {31'b0, bus_if.ack}, 32'd1);
        check("b2b_second_data", bus_if.data_r, 32'h00BB0077);
        bus_if.re = 1'b0;
        @(negedge clk);
        check("b2b_ack_low", {31'b0, bus_if.ack}, 32'd0);

        // Reset in the AMO_MOD cycle: no write, no ack, reservation lost.
        do_req(0,1,0,OP_ADD, 4'hF, 32'h50, 32'h100, rd, lat);
        do_req(1,0,1,OP_LR,  4'h0, 32'h50, 32'h0,   rd, lat);
        check("rst_lr_data", rd, 32'h100);
        bus_if.re = 1'b1; bus_if.atomic = 1'b1; bus_if.amo_op = OP_ADD;
        bus_if.addr = 32'h50; bus_if.data_w = 32'h1;
        @(negedge clk);
        check("amo_mod_no_ack", {31'b0, bus_if.ack}, 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_amo_ack", {31'b0, bus_if.ack}, 32'd0);
        check("rst_amo_data_r", bus_if.data_r, 32'd0);
        bus_if.re = 1'b0; bus_if.atomic = 1'b0;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_no_late_ack", {31'b0, bus_if.ack}, 32'd0);
        end
        do_req(0,1,1,OP_SC,  4'h0, 32'h50, 32'h777, rd, lat);
        check("rst_sc_fails", rd, 32'h1);
        do_req(1,0,0,OP_ADD, 4'h0, 32'h50, 32'h0,   rd, lat);
        check("rst_word_unchanged", rd, 32'h100);

        // Randomized traffic over 16 words against the reference model.
        m_rv = 1'b0;
        m_ridx = 0;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ed;
            int          el;
            logic [31:0] dw = $urandom;
            model(1'b1, 1'b0, OP_ADD, 4'hF, i, dw, ed, el);
            do_req(0,1,0,OP_ADD, 4'hF, 32'(i) << 2, dw, rd, lat);
            check($sformatf("init%0d_data", i), rd, ed);
        end
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ed;
            int          el;
            int          k = int'($urandom_range(0, 6));
            int          idx = int'($urandom_range(0, 15));
            logic [31:0] dw = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            logic [3:0]  sel = 4'($urandom);
            logic [4:0]  op = OP_ADD;
            logic        re = 1'b0;
            logic        we = 1'b0;
            logic        at = 1'b0;
            logic [31:0] addr;
            case (k)
                0: re = 1'b1;
                1: we = 1'b1;
                2: begin re = 1'b1; we = 1'b1; end
                3: begin at = 1'b1; op = OP_LR; end
                4: begin
                    at = 1'b1; op = OP_SC;
                    if (m_rv && $urandom_range(0, 1) == 1) idx = m_ridx;
                end
                5: begin
                    at = 1'b1;
                    case ($urandom_range(0, 8))
                        0: op = OP_ADD;  1: op = OP_SWAP; 2: op = OP_XOR;
                        3: op = OP_OR;   4: op = OP_AND;  5: op = OP_MIN;
                        6: op = OP_MAX;  7: op = OP_MINU; default: op = OP_MAXU;
                    endcase
                end
                default: begin
                    at = 1'b1;
                    do op = 5'($urandom_range(0, 31));
                    while (is_rmw(op) || op == OP_LR || op == OP_SC);
                end
            endcase
            if (at) begin
                re = 1'($urandom);
                we = 1'($urandom);
            end
            addr = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            model(we, at, op, sel, idx, dw, ed, el);
            do_req(re, we, at, op, sel, addr, dw, rd, lat);
            check($sformatf("rnd%0d_k%0d_data", n, k), rd, ed);
            check($sformatf("rnd%0d_k%0d_latency", n, k), lat, el);
        end
        for (int i = 0; i < 16; i++) begin
            do_req(1,0,0,OP_ADD, 4'h0, 32'(i) << 2, 32'h0, rd, lat);
            check($sformatf("final_word%0d", i), rd, m_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
